seq_detect_fsm: RTL and testbench

Parametrised Moore sequence-detector FSM with asynchronous reset. It generalises the two-state in-follower FSM to a (PATTERN_W+1)-state prefix-tracking machine that detects a programmable serial bit pattern. It has selectable overlapping or non-overlapping detection, a sample-enable, a synchronous clear and a saturating match counter. It sits on a serial bit stream and flags pattern occurrences to downstream control logic.

---
 rtl/seq_detect_fsm.sv | 112 +++++++++++
 tb/tb_seq_detect_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_fsm.sv
// Moore sequence detector: tracks the longest matched prefix of PATTERN on a
// serial bit stream and counts (saturating) completed matches.
module seq_detect_fsm #(
  parameter int unsigned            PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0]   PATTERN   = 4'b1011,
  parameter bit                     OVERLAP   = 1'b1,
  parameter int unsigned            COUNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           areset,
  input  logic                           en_i,
  input  logic                           in_i,
  input  logic                           clear_i,
  output logic                           match_o,
  output logic [$clog2(PATTERN_W+1)-1:0] state_o,
  output logic [COUNT_W-1:0]             match_count_o
);

  localparam int unsigned SW    = $clog2(PATTERN_W + 1);
  localparam int unsigned NE    = 2 * (PATTERN_W + 1);
  localparam int unsigned TBL_W = NE * SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t              S_IDLE  = '0;
  localparam state_t              S_MATCH = SW'(PATTERN_W);
  localparam logic [COUNT_W-1:0]  CNT_MAX = '1;

  // Bit n of the pattern (n = 0 is the last bit received).
  function automatic logic pat_bit(input int unsigned n);
    logic [31:0] v;
    v = 32'(PATTERN) >> n;
    return v[0];
  endfunction

  // Next-state table, entry index {k, b}: longest pattern prefix that is a
  // suffix of (H . b), H being the top k pattern bits (empty from S_MATCH
  // when overlapping matches are disabled).
  function automatic logic [TBL_W-1:0] build_table();
    logic [TBL_W-1:0] tbl;
    int unsigned      h;
    int unsigned      best;
    int unsigned      pos;
    logic             ok;
    logic             sbit;
    tbl = '0;
    for (int unsigned k = 0; k <= PATTERN_W; k++) begin
      for (int unsigned b = 0; b < 2; b++) begin
        h    = (k == PATTERN_W && !OVERLAP) ? 0 : k;
        best = 0;
        for (int unsigned j = 1; j <= PATTERN_W; j++) begin
          if (j <= h + 1) begin
            ok = 1'b1;
            for (int unsigned i = 0; i < j; i++) begin
              pos  = h + 1 - j + i;
              sbit = (pos == h) ? b[0] : pat_bit(PATTERN_W - 1 - pos);
              if (sbit != pat_bit(PATTERN_W - 1 - i)) ok = 1'b0;
            end
            if (ok) best = j;
          end
        end
        tbl = tbl | (TBL_W'(best) << ((k * 2 + b) * SW));
      end
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] NEXT_TBL = build_table();

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               match_q, match_d;
  logic [SW:0]        entry;
  logic [TBL_W-1:0]   tbl_shift;
  state_t             nxt;

  // Next-state and counter logic; clear outranks the sample enable.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    entry     = {state_q, in_i};
    tbl_shift = NEXT_TBL >> (32'(entry) * SW);
    nxt       = tbl_shift[SW-1:0];
    if (clear_i) begin
      state_d = S_IDLE;
      count_d = '0;
    end else if (en_i) begin
      state_d = nxt;
      if (nxt == S_MATCH && count_q != CNT_MAX) begin
        count_d = count_q + COUNT_W'(1);
      end
    end
    match_d = (state_d == S_MATCH);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      match_q <= match_d;
    end
  end

  assign match_o       = match_q;
  assign state_o       = state_q;
  assign match_count_o = count_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: three configurations share one stimulus stream;
// a history-based model feeds an expectation queue drained by a monitor.
module tb_seq_detect_fsm;

  localparam int unsigned ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       areset = 1'b0;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       clr = 1'b0;
  logic       m_a, m_b, m_c;
  logic [2:0] st_a, st_b;
  logic [1:0] st_c;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] cnt_c;

  seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(8)) u_a (
    .clk(clk), .areset(areset), .en_i(en), .in_i(din), .clear_i(clr),
    .match_o(m_a), .state_o(st_a), .match_count_o(cnt_a));

  seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_W(2)) u_b (
    .clk(clk), .areset(areset), .en_i(en), .in_i(din), .clear_i(clr),
    .match_o(m_b), .state_o(st_b), .match_count_o(cnt_b));

  seq_detect_fsm #(.PATTERN_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .COUNT_W(3)) u_c (
    .clk(clk), .areset(areset), .en_i(en), .in_i(din), .clear_i(clr),
    .match_o(m_c), .state_o(st_c), .match_count_o(cnt_c));

  int unsigned pw   [ND] = '{4, 4, 3};
  logic [31:0] pat  [ND] = '{32'hB, 32'hB, 32'h7};
  bit          ovl  [ND] = '{1'b1, 1'b0, 1'b1};
  int unsigned cmax [ND] = '{255, 3, 7};

  logic [63:0] hist [ND];
  int unsigned hlen [ND];
  int unsigned mst  [ND];
  int unsigned mcnt [ND];

  typedef struct packed {
    logic [ND-1:0][7:0] st;
    logic [ND-1:0]      m;
    logic [ND-1:0][7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  // Longest j such that the last j history bits equal the first j pattern bits.
  function automatic int unsigned prefix_len(input logic [63:0] h, input int unsigned hl,
                                             input int unsigned w, input logic [31:0] p);
    int unsigned best;
    logic [63:0] mask;
    best = 0;
    for (int unsigned j = 1; j <= w; j++) begin
      if (j <= hl) begin
        mask = (64'd1 << j) - 64'd1;
        if ((h & mask) == (64'(p) >> (w - j))) best = j;
      end
    end
    return best;
  endfunction

  task automatic model_step(input logic rst, input logic e, input logic b, input logic c);
    exp_t x;
    for (int d = 0; d < ND; d++) begin
      if (rst || c) begin
        hist[d] = '0; hlen[d] = 0; mst[d] = 0; mcnt[d] = 0;
      end else if (e) begin
        hist[d] = {hist[d][62:0], b};
        if (hlen[d] < 64) hlen[d]++;
        mst[d] = prefix_len(hist[d], hlen[d], pw[d], pat[d]);
        if (mst[d] == pw[d]) begin
          if (mcnt[d] < cmax[d]) mcnt[d]++;
          if (!ovl[d]) begin
            hist[d] = '0; hlen[d] = 0;
          end
        end
      end
      x.st[d]  = 8'(mst[d]);
      x.m[d]   = (mst[d] == pw[d]);
      x.cnt[d] = 8'(mcnt[d]);
    end
    exp_q.push_back(x);
  endtask

  task automatic cyc(input logic e, input logic b, input logic c);
    en = e; din = b; clr = c;
    model_step(areset, e, b, c);
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    logic [31:0] v;
    for (int i = n - 1; i >= 0; i--) begin
      v = bits >> i;
      cyc(1'b1, v[0], 1'b0);
    end
  endtask

  // Monitor: every edge that consumed stimulus has one queued expectation.
  always @(posedge clk) begin
    exp_t x;
    logic [ND-1:0][7:0] a_st;
    logic [ND-1:0]      a_m;
    logic [ND-1:0][7:0] a_cnt;
    #2;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      a_st  = {8'(st_c), 8'(st_b), 8'(st_a)};
      a_m   = {m_c, m_b, m_a};
      a_cnt = {8'(cnt_c), 8'(cnt_b), 8'(cnt_a)};
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("mon state[%0d]", d), a_st[d], x.st[d]);
        chk($sformatf("mon match[%0d]", d), a_m[d], x.m[d]);
        chk($sformatf("mon count[%0d]", d), a_cnt[d], x.cnt[d]);
      end
    end
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      hist[d] = '0; hlen[d] = 0; mst[d] = 0; mcnt[d] = 0;
    end
    #2 areset = 1'b1;
    #1;
    chk("por state_a", st_a, 0);
    chk("por match_a", m_a, 0);
    chk("por count_a", cnt_a, 0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    areset = 1'b0;

    // Basic 1011
    feed(32'hB, 4);
    chk("basic state_a", st_a, 4);
    chk("basic match_a", m_a, 1);
    chk("basic count_a", cnt_a, 1);

    // Overlap versus restart after a match
    cyc(1'b0, 1'b0, 1'b1);
    feed(32'b1011011, 7);
    chk("ovl count_a", cnt_a, 2);
    chk("ovl match_a", m_a, 1);
    chk("novl count_b", cnt_b, 1);
    chk("novl state_b", st_b, 1);

    // Enable gaps with in toggling
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0); cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0); cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    chk("gap match_a", m_a, 1);
    chk("gap count_a", cnt_a, 1);

    // Saturation of the 2-bit counter
    cyc(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++) feed(32'hB, 4);
    chk("sat count_b", cnt_b, 3);
    chk("sat count_a", cnt_a, 5);

    // Clear wins over en/in
    cyc(1'b0, 1'b0, 1'b1);
    feed(32'b101, 3);
    chk("pre-clear state_a", st_a, 3);
    cyc(1'b1, 1'b1, 1'b1);
    chk("clr state_a", st_a, 0);
    chk("clr count_a", cnt_a, 0);
    chk("clr match_a", m_a, 0);
    feed(32'hB, 4);
    chk("post-clr count_a", cnt_a, 1);

    // Asynchronous reset between edges
    cyc(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++) feed(32'hB, 4);
    feed(32'b101, 3);
    chk("pre-rst state_a", st_a, 3);
    chk("pre-rst count_a", cnt_a, 5);
    #4 areset = 1'b1;
    #1;
    chk("arst state_a", st_a, 0);
    chk("arst match_a", m_a, 0);
    chk("arst count_a", cnt_a, 0);
    chk("arst count_b", cnt_b, 0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    areset = 1'b0;

    // Random stream
    for (int i = 0; i < 1500; i++) begin
      cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 49) == 0));
    end

    #5;
    chk("queue drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
